// File: rtl/axi_decerr_slave.sv
// AXI default slave: accepts any transaction and completes it with DECERR.
// Optional error logging (err_cnt/err_addr) is enabled with `define AXI_DECERR_LOG_EN.
module axi_decerr_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [LEN_W-1:0]    arlen,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
`ifdef AXI_DECERR_LOG_EN
    ,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   err_addr
`endif
);
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t         w_state;
    r_state_t         r_state;
    logic [ID_W-1:0]  wid_q;
    logic [ID_W-1:0]  rid_q;
    logic [LEN_W-1:0] cnt;

    // Payload, lengths of writes and addresses carry no meaning for a decode-error sink.
    logic unused;
    assign unused = ^{awaddr, awlen, wdata, wstrb, araddr};

    assign rdata = '0;
    assign bresp = DECERR;
    assign rresp = DECERR;
    assign bid   = wid_q;
    assign rid   = rid_q;

    // Write path: one AW, drain W until WLAST, then a single B.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            wid_q   <= '0;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid && awready) begin
                    wid_q   <= awid;
                    w_state <= W_DATA;
                    awready <= 1'b0;
                    wready  <= 1'b1;
                end
                W_DATA: if (wvalid && wlast) begin
                    w_state <= W_RESP;
                    wready  <= 1'b0;
                    bvalid  <= 1'b1;
                end
                W_RESP: if (bready) begin
                    w_state <= W_IDLE;
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b1;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read path: cnt holds beats remaining after the current one, so rlast is cnt==0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            rid_q   <= '0;
            cnt     <= '0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid && arready) begin
                    rid_q   <= arid;
                    cnt     <= arlen;
                    r_state <= R_DATA;
                    arready <= 1'b0;
                    rvalid  <= 1'b1;
                    rlast   <= (arlen == '0);
                end
                R_DATA: if (rready) begin
                    if (cnt == '0) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        rlast <= (cnt == LEN_W'(1));
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                    rlast   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_DECERR_LOG_EN
    logic        b_hs, r_fin;
    logic [16:0] cnt_sum;
    assign b_hs    = bvalid && bready;
    assign r_fin   = rvalid && rready && rlast;
    assign cnt_sum = {1'b0, err_cnt} + 17'(b_hs) + 17'(r_fin);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (arvalid && arready)
                err_addr <= araddr;
            else if (awvalid && awready)
                err_addr <= awaddr;
        end
    end
`endif

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Bench for axi_decerr_slave: vector table plus scoreboard of expected R/B beats.
module tb_axi_decerr_slave;
    localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [ID_W-1:0] awid, arid, bid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [LEN_W-1:0] awlen, arlen;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [1:0] bresp, rresp;
`ifdef AXI_DECERR_LOG_EN
    logic [15:0] err_cnt;
    logic [ADDR_W-1:0] err_addr;
`endif

    axi_decerr_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI_DECERR_LOG_EN
        , .err_cnt(err_cnt), .err_addr(err_addr)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rbeats = 0, bcount = 0;
    bit rmode = 1'b0;

    typedef struct { logic [ID_W-1:0] id; logic last; } beat_t;
    beat_t rq[$];
    logic [ID_W-1:0] bq[$];

    typedef struct {
        bit do_rd; bit do_wr;
        logic [ID_W-1:0] rd_id; logic [LEN_W-1:0] rd_len;
        logic [ID_W-1:0] wr_id; logic [LEN_W-1:0] wr_len;
        bit rtoggle;
        int exp_rbeats; int exp_b;
    } vec_t;
    vec_t vecs[5];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: samples at the clock edge, before the DUT updates.
    beat_t rexp;
    logic [ID_W-1:0] bexp, prid, pbid;
    logic stall_r = 1'b0, stall_b = 1'b0, prlast = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            stall_r = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_r) begin
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_id", 32'(rid), 32'(prid));
                check("r_hold_last", 32'(rlast), 32'(prlast));
            end
            if (stall_b) begin
                check("b_hold_valid", 32'(bvalid), 32'd1);
                check("b_hold_id", 32'(bid), 32'(pbid));
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_extra_beat", 32'(rvalid), 32'd0);
                else begin
                    rexp = rq.pop_front();
                    check("r_id", 32'(rid), 32'(rexp.id));
                    check("r_last", 32'(rlast), 32'(rexp.last));
                    check("r_data", rdata, 32'd0);
                    check("r_resp", 32'(rresp), 32'd3);
                    rbeats++;
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) check("b_extra", 32'(bvalid), 32'd0);
                else begin
                    bexp = bq.pop_front();
                    check("b_id", 32'(bid), 32'(bexp));
                    check("b_resp", 32'(bresp), 32'd3);
                    bcount++;
                end
            end
            stall_r = rvalid && !rready;
            stall_b = bvalid && !bready;
            prid = rid; prlast = rlast; pbid = bid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) rready = ~rready;
    endtask

    task automatic push_rd(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
        for (int i = 0; i <= int'(len); i++) rq.push_back('{id, i == int'(len)});
    endtask

    task automatic drive_w(input logic [LEN_W-1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wlast  = (i == int'(len));
            wdata  = $urandom;
            check("w_ready", 32'(wready), 32'd1);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0 || !arready || !awready) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 32'(rq.size() + bq.size()), 32'd0);
        rmode  = 1'b0;
        rready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 8'h11, 4'd0, 8'h00, 4'd0, 1, 1, 0};
        vecs[1] = '{1, 0, 8'h33, 4'd3, 8'h00, 4'd0, 1, 4, 0};
        vecs[2] = '{1, 1, 8'h01, 4'd1, 8'h02, 4'd0, 0, 2, 1};
        vecs[3] = '{1, 0, 8'hFF, 4'd15, 8'h00, 4'd0, 0, 16, 0};
        vecs[4] = '{1, 1, 8'h44, 4'd2, 8'h7E, 4'd3, 1, 3, 1};

        rst = 1'b0;
        {awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid} = '0;
        {arid, araddr, arlen, arvalid} = '0;
        bready = 1'b1;
        rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_ids", 32'({bid, rid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'hF);
        rst = 1'b1;
        tick();

        // Single read: beat next cycle, arready back the cycle after.
        arid = 8'h5A; arlen = 4'd0; arvalid = 1'b1;
        push_rd(8'h5A, 4'd0);
        tick();
        arvalid = 1'b0;
        check("sr_rvalid", 32'(rvalid), 32'd1);
        check("sr_rlast", 32'(rlast), 32'd1);
        check("sr_rid", 32'(rid), 32'h5A);
        check("sr_arready_busy", 32'(arready), 32'd0);
        tick();
        check("sr_arready_back", 32'(arready), 32'd1);
        check("sr_rvalid_done", 32'(rvalid), 32'd0);

        // Write burst with a stray early W beat and B backpressure.
        bready = 1'b0;
        wvalid = 1'b1;
        tick();
        check("w_idle_wready", 32'(wready), 32'd0);
        wvalid = 1'b0;
        awid = 8'h21; awlen = 4'd2; awaddr = 32'h1000; awvalid = 1'b1;
        check("wb_awready", 32'(awready), 32'd1);
        bq.push_back(8'h21);
        tick();
        awvalid = 1'b0;
        check("wb_awready_busy", 32'(awready), 32'd0);
        drive_w(4'd2);
        check("wb_bvalid", 32'(bvalid), 32'd1);
        check("wb_bid", 32'(bid), 32'h21);
        check("wb_bresp", 32'(bresp), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wb_bvalid_hold", 32'(bvalid), 32'd1);
            check("wb_bid_hold", 32'(bid), 32'h21);
        end
        bready = 1'b1;
        tick();
        check("wb_bvalid_done", 32'(bvalid), 32'd0);
        check("wb_awready_back", 32'(awready), 32'd1);

        // Vector table: reads, writes and concurrent pairs.
        foreach (vecs[v]) begin
            rmode = vecs[v].rtoggle;
            rready = 1'b1;
            rbeats = 0;
            bcount = 0;
            if (vecs[v].do_rd) begin
                arid = vecs[v].rd_id; arlen = vecs[v].rd_len; araddr = $urandom; arvalid = 1'b1;
                push_rd(vecs[v].rd_id, vecs[v].rd_len);
                check("vec_arready", 32'(arready), 32'd1);
            end
            if (vecs[v].do_wr) begin
                awid = vecs[v].wr_id; awlen = vecs[v].wr_len; awaddr = $urandom; awvalid = 1'b1;
                bq.push_back(vecs[v].wr_id);
                check("vec_awready", 32'(awready), 32'd1);
            end
            tick();
            arvalid = 1'b0;
            awvalid = 1'b0;
            if (vecs[v].do_wr) drive_w(vecs[v].wr_len);
            wait_idle(200);
            check("vec_rbeats", 32'(rbeats), 32'(vecs[v].exp_rbeats));
            check("vec_bcount", 32'(bcount), 32'(vecs[v].exp_b));
        end

        // Reset during beat 2 of an 8-beat read.
        arid = 8'h3C; arlen = 4'd7; arvalid = 1'b1;
        push_rd(8'h3C, 4'd7);
        tick();
        arvalid = 1'b0;
        tick();
        check("mr_beat2_valid", 32'(rvalid), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_rvalid_rst", 32'(rvalid), 32'd0);
        check("mr_arready_rst", 32'(arready), 32'd1);
        check("mr_rid_rst", 32'(rid), 32'd0);
        rq.delete();
        tick();
        rst = 1'b1;
        tick();
        check("mr_arready_after", 32'(arready), 32'd1);
        rbeats = 0;
        arid = 8'h09; arlen = 4'd0; arvalid = 1'b1;
        push_rd(8'h09, 4'd0);
        tick();
        arvalid = 1'b0;
        check("mr_next_rlast", 32'(rlast), 32'd1);
        wait_idle(20);
        check("mr_next_beats", 32'(rbeats), 32'd1);

`ifdef AXI_DECERR_LOG_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("log_rst_cnt", 32'(err_cnt), 32'd0);
        check("log_rst_addr", err_addr, 32'd0);
        for (int i = 1; i <= 2; i++) begin
            awid = 8'(i); awlen = 4'd0; awaddr = 32'(i * 32'h100); awvalid = 1'b1;
            bq.push_back(8'(i));
            tick();
            awvalid = 1'b0;
            drive_w(4'd0);
            wait_idle(20);
        end
        check("log_addr_w2", err_addr, 32'h200);
        arid = 8'h03; arlen = 4'd1; araddr = 32'h300; arvalid = 1'b1;
        push_rd(8'h03, 4'd1);
        tick();
        arvalid = 1'b0;
        wait_idle(20);
        check("log_cnt_3", 32'(err_cnt), 32'd3);
        // Final R and B handshakes land on the same edge.
        rready = 1'b0;
        awid = 8'h04; awlen = 4'd0; awaddr = 32'h400; awvalid = 1'b1;
        arid = 8'h05; arlen = 4'd0; araddr = 32'h500; arvalid = 1'b1;
        bq.push_back(8'h04);
        push_rd(8'h05, 4'd0);
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        check("log_addr_ar_wins", err_addr, 32'h500);
        wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        check("log_both_valid", 32'({rvalid, bvalid}), 32'd3);
        rready = 1'b1;
        tick();
        check("log_cnt_5", 32'(err_cnt), 32'd5);
        check("log_addr_last", err_addr, 32'h500);
        wait_idle(20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- Parametrised AXI default (decode-error) slave.
- Sits on the interconnect's default slave port and receives any transaction whose address matches no mapped slave.
- Read and write channels run independently and concurrently.
- Supports bursts: the full ARLEN+1 read beats are returned, and write data is drained until WLAST.
- Every transaction completes with DECERR, so masters never hang on unmapped addresses.

Parameters:
- ID_W, 8, width of AWID/ARID/BID/RID.
- ADDR_W, 32, address width.
- DATA_W, 32, RDATA/WDATA width.
- LEN_W, 4, width of AWLEN/ARLEN (burst length = LEN+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- awid  in  ID_W  write address ID
- awaddr  in  ADDR_W  write address
- awlen  in  LEN_W  write burst length-1
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_W  write data (ignored)
- wstrb  in  DATA_W/8  write strobes (ignored)
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid  in  ID_W  read address ID
- araddr  in  ADDR_W  read address
- arlen  in  LEN_W  read burst length-1
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  read ID
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready

Behaviour:
- Reset (rst low, asynchronous): both FSMs go to IDLE and captured IDs/counter clear to 0.
  - Outputs during reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0.
  - Any in-flight transaction is discarded.
- Constant outputs: rdata=0; bresp and rresp = DECERR (2'b11).
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, wready=0. On awvalid&awready, capture awid into wid_q and go to W_DATA. The next transaction is not accepted until W_IDLE is re-entered.
  - W_DATA: awready=0, wready=1. Each wvalid beat is accepted and discarded. On wvalid&wlast, go to W_RESP.
  - W beats are terminated by WLAST only; awlen is not counted. A W beat presented while in W_IDLE waits (wready=0).
  - W_RESP: bvalid=1, bid=wid_q. On bready, go to W_IDLE; awready is high the following cycle.
  - Minimum write latency: AW handshake at cycle N, first wready at N+1, bvalid at the cycle after the WLAST handshake.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1, rvalid=0. On handshake, capture arid into rid_q and load beat counter cnt=arlen, then go to R_DATA.
  - R_DATA: arready=0, rvalid=1, rid=rid_q, rlast=(cnt==0).
  - On rvalid&rready: if cnt==0, go to R_IDLE; otherwise cnt decrements.
  - First rvalid appears one cycle after the AR handshake. A single-beat read (arlen=0) asserts rlast on its only beat.
  - Maximum burst (arlen = 2^LEN_W-1) returns exactly 2^LEN_W beats; the counter never wraps.
- Simultaneous events:
  - AW and AR accepted in the same cycle are both legal and proceed independently.
  - B and final R handshakes may coincide.
- Valid stability: rvalid and bvalid, once asserted, stay high until their handshake. rid, bid and rlast stay stable while the corresponding valid is high.

Optional Feature:
- Macro: AXI_DECERR_LOG_EN
- When defined:
  - Adds output err_cnt [15:0]: a saturating count of completed error transactions. It increments by 1 on a B handshake and by 1 on the final R handshake, by 2 if both occur in the same cycle, and saturates at 16'hFFFF.
  - Adds output err_addr [ADDR_W-1:0]: latches the address of the most recent AW or AR handshake; AR wins if both occur in the same cycle.
  - Both outputs reset to 0.
- When not defined: neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Single read: AR arid=8'h5A, arlen=0, rready=1 → one beat next cycle with rid=5A, rdata=0, rresp=3, rlast=1; arready high again the cycle after.
- Burst read with backpressure: arlen=3, rready toggling 1,0,1,0… → exactly 4 beats, rlast only on the 4th, rvalid held through stalls, no extra beats.
- Write burst: AW awid=8'h21, awlen=2, then 3 W beats with wlast on the 3rd → bvalid=1 with bid=21, bresp=3 the cycle after WLAST; with bready held low for 5 cycles, bvalid and bid remain stable.
- Concurrency: AR (id 1, arlen=1) and AW (id 2) in the same cycle → arready=awready=1 in that cycle, and both complete with correct IDs; the read returns 2 beats.
- Reset mid-burst: assert rst during beat 2 of an arlen=7 read → rvalid=0 immediately, arready=1 after reset deasserts, and the next read (arlen=0) behaves normally.
- AXI_DECERR_LOG_EN defined: 3 writes plus 2 reads (one read's final R handshake coinciding with a B handshake) → err_cnt=5; err_addr equals the last handshaken address.
